// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Two-requester round-robin arbiter and sequencer in front of a
//             16 x 8 single-port RAM with a valid/ready command port.
//             Serialises A/B commands, returns registered read data and a
//             one-cycle done/err pulse to the winner, and aborts a command
//             that sees no ram_ready within TIMEOUT cycles.
//  Revision : 1.0  initial release
// ============================================================================
module ram_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  // requester A
  input  logic              a_valid,
  input  logic              a_wr_rd,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_done,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  // requester B
  input  logic              b_valid,
  input  logic              b_wr_rd,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_done,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  // RAM command port
  output logic              ram_valid,
  output logic              ram_wr_rd,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Last counter value before the command is abandoned.
  localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state;
  logic              r_last_b;     // 1 = B received the most recent grant
  logic              w_last_b;
  logic [7:0]        r_count;      // cycles spent in ISSUE without ram_ready
  logic [7:0]        w_count;
  logic              w_sel_b;      // B would win if a grant were made now

  logic              w_ram_valid;
  logic              w_ram_wr_rd;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic              w_a_done;
  logic              w_b_done;
  logic              w_a_err;
  logic              w_b_err;
  logic [DATA_W-1:0] w_a_rdata;
  logic [DATA_W-1:0] w_b_rdata;

  // Next-state and next-output logic; everything holds unless a rule below changes it.
  always_comb begin
    w_state     = r_state;
    w_last_b    = r_last_b;
    w_count     = r_count;
    w_ram_valid = ram_valid;
    w_ram_wr_rd = ram_wr_rd;
    w_ram_addr  = ram_addr;
    w_ram_wdata = ram_wdata;
    w_a_rdata   = a_rdata;
    w_b_rdata   = b_rdata;
    w_a_done    = 1'b0;
    w_b_done    = 1'b0;
    w_a_err     = 1'b0;
    w_b_err     = 1'b0;
    // A lone requester wins; on contention the one not granted last time wins.
    w_sel_b     = b_valid && (!a_valid || !r_last_b);

    case (r_state)
      IDLE: begin
        if (a_valid || b_valid) begin
          w_last_b    = w_sel_b;
          w_ram_valid = 1'b1;
          w_ram_wr_rd = w_sel_b ? b_wr_rd : a_wr_rd;
          w_ram_addr  = w_sel_b ? b_addr  : a_addr;
          w_ram_wdata = w_sel_b ? b_wdata : a_wdata;
          w_count     = 8'd0;
          w_state     = ISSUE;
        end
      end
      ISSUE: begin
        if (ram_ready) begin
          // Success wins even on the final timeout cycle.
          w_ram_valid = 1'b0;
          if (!ram_wr_rd) begin
            if (r_last_b) begin
              w_b_rdata = ram_rdata;
            end else begin
              w_a_rdata = ram_rdata;
            end
          end
          w_a_done = !r_last_b;
          w_b_done = r_last_b;
          w_state  = RESP;
        end else if (r_count == C_TIMEOUT_LAST) begin
          w_ram_valid = 1'b0;
          w_a_done    = !r_last_b;
          w_b_done    = r_last_b;
          w_a_err     = !r_last_b;
          w_b_err     = r_last_b;
          w_state     = RESP;
        end else begin
          w_count = r_count + 8'd1;
        end
      end
      RESP: begin
        // done/err are high for exactly this cycle; they default back to 0.
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset discards any in-flight command.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last_b  <= 1'b1;
      r_count   <= 8'd0;
      ram_valid <= 1'b0;
      ram_wr_rd <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      a_done    <= 1'b0;
      b_done    <= 1'b0;
      a_err     <= 1'b0;
      b_err     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      r_state   <= w_state;
      r_last_b  <= w_last_b;
      r_count   <= w_count;
      ram_valid <= w_ram_valid;
      ram_wr_rd <= w_ram_wr_rd;
      ram_addr  <= w_ram_addr;
      ram_wdata <= w_ram_wdata;
      a_done    <= w_a_done;
      b_done    <= w_b_done;
      a_err     <= w_a_err;
      b_err     <= w_b_err;
      a_rdata   <= w_a_rdata;
      b_rdata   <= w_b_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_arbiter
//  Purpose  : Self-checking bench for ram_arbiter: directed vector table,
//             multi-cycle corner sequences and a randomized phase, all
//             checked against a transaction-timing reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_arbiter;

  localparam int TO = 15;

  logic       clk;
  logic       rst;
  logic       a_valid, a_wr_rd, b_valid, b_wr_rd;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_done, a_err, b_done, b_err;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_valid, ram_wr_rd, ram_ready;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;

  ram_arbiter #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_wr_rd(a_wr_rd), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_wr_rd(b_wr_rd), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
    .ram_valid(ram_valid), .ram_wr_rd(ram_wr_rd), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model storage (follows the DUT's command port) and reference memory.
  logic [7:0] ram_mem [16];
  logic [7:0] mem_ref [16];
  assign ram_rdata = ram_mem[ram_addr];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state.
  bit         busy, win_b, last_b, t_err;
  int         t_done, idle_from;
  bit         m_wr;
  logic [3:0] m_addr;
  logic [7:0] m_wdata, exp_ard, exp_brd;
  bit         ev_a, ev_b;
  // RAM responder state.
  int         vcnt, ready_delay;
  bit         stray_ready;
  bit         hs_pend;
  logic [3:0] hs_addr;
  logic [7:0] hs_data;

  typedef struct {
    bit         who_b;
    bit         wr;
    logic [3:0] addr;
    logic [7:0] wdata;
    int         delay;
    bit         exp_err;
    logic [7:0] exp_rdata;
    int         exp_len;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event did not occur within its cycle budget (cycle %0d)", name, cyc);
  endtask

  // One clock: sample and check at the falling edge, then drive the RAM responder.
  task automatic step();
    bit exp_v, dn;
    @(negedge clk);
    cyc++;
    ev_a = 1'b0;
    ev_b = 1'b0;
    if (hs_pend && !rst) ram_mem[hs_addr] = hs_data;
    hs_pend = 1'b0;
    if (rst) begin
      chk("rst_ram_valid", ram_valid, 0);
      chk("rst_ram_wr_rd", ram_wr_rd, 0);
      chk("rst_ram_addr",  ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_done", {a_done, b_done, a_err, b_err}, 0);
      chk("rst_a_rdata", a_rdata, 0);
      chk("rst_b_rdata", b_rdata, 0);
      busy = 1'b0; last_b = 1'b1; exp_ard = 8'h00; exp_brd = 8'h00;
      idle_from = cyc;
    end else begin
      if (!busy && (cyc - 1) >= idle_from && (a_valid || b_valid)) begin
        win_b   = b_valid && (!a_valid || !last_b);
        last_b  = win_b;
        busy    = 1'b1;
        m_wr    = win_b ? b_wr_rd : a_wr_rd;
        m_addr  = win_b ? b_addr  : a_addr;
        m_wdata = win_b ? b_wdata : a_wdata;
        t_done  = cyc + ((ready_delay < TO - 1) ? ready_delay : TO - 1) + 1;
        t_err   = (ready_delay >= TO);
      end
      exp_v = busy && (cyc < t_done);
      dn    = busy && (cyc == t_done);
      chk("ram_valid", ram_valid, exp_v);
      if (exp_v) begin
        chk("ram_wr_rd", ram_wr_rd, m_wr);
        chk("ram_addr",  ram_addr,  m_addr);
        chk("ram_wdata", ram_wdata, m_wdata);
      end
      if (dn && !t_err) begin
        if (m_wr) mem_ref[m_addr] = m_wdata;
        else if (win_b) exp_brd = mem_ref[m_addr];
        else exp_ard = mem_ref[m_addr];
      end
      chk("a_done", a_done, dn && !win_b);
      chk("b_done", b_done, dn && win_b);
      chk("a_err",  a_err,  dn && !win_b && t_err);
      chk("b_err",  b_err,  dn && win_b && t_err);
      chk("a_rdata", a_rdata, exp_ard);
      chk("b_rdata", b_rdata, exp_brd);
      if (dn) begin
        busy = 1'b0; idle_from = cyc + 1;
        ev_a = !win_b; ev_b = win_b;
      end
    end
    if (ram_valid) begin
      vcnt++;
      ram_ready = (vcnt > ready_delay);
    end else begin
      vcnt = 0;
      ram_ready = stray_ready;
    end
    if (ram_valid && ram_ready && ram_wr_rd) begin
      hs_pend = 1'b1; hs_addr = ram_addr; hs_data = ram_wdata;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_grant(input string name);
    for (int k = 0; k < 20 && !busy; k++) step();
    if (!busy) note_fail(name);
  endtask

  task automatic drain();
    a_valid = 1'b0; b_valid = 1'b0;
    for (int k = 0; k < 300 && busy; k++) step();
    step(); step();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int nv;
    bit got;
    ready_delay = v.delay;
    if (v.who_b) begin
      b_valid = 1'b1; b_wr_rd = v.wr; b_addr = v.addr; b_wdata = v.wdata;
    end else begin
      a_valid = 1'b1; a_wr_rd = v.wr; a_addr = v.addr; a_wdata = v.wdata;
    end
    nv = 0; got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      step();
      if (ram_valid) nv++;
      if (ev_a || ev_b) begin
        got = 1'b1;
        chk($sformatf("vec%0d_done", idx),  v.who_b ? b_done  : a_done, 1);
        chk($sformatf("vec%0d_err", idx),   v.who_b ? b_err   : a_err,  v.exp_err);
        chk($sformatf("vec%0d_rdata", idx), v.who_b ? b_rdata : a_rdata, v.exp_rdata);
        chk($sformatf("vec%0d_len", idx),   nv, v.exp_len);
      end
    end
    if (!got) note_fail($sformatf("vec%0d_wait", idx));
    a_valid = 1'b0; b_valid = 1'b0;
    step();
  endtask

  task automatic new_cmd(input bit is_b);
    if (is_b) begin
      b_valid = 1'b1; b_wr_rd = 1'($urandom); b_addr = 4'($urandom); b_wdata = 8'($urandom);
    end else begin
      a_valid = 1'b1; a_wr_rd = 1'($urandom); a_addr = 4'($urandom); a_wdata = 8'($urandom);
    end
  endtask

  function automatic int pick_delay();
    case ($urandom_range(0, 9))
      0, 1, 2: return 0;
      3:       return 1;
      4:       return 2;
      5:       return 5;
      6:       return TO - 2;
      7:       return TO - 1;
      8:       return TO;
      default: return 255;
    endcase
  endfunction

  initial begin
    bit          who [4];
    int          tm  [4];
    int          n;
    logic [7:0]  v;

    //                who  wr  addr   wdata  dly err rdata  len
    vecs[0]  = '{1'b0, 1'b1, 4'h3, 8'hA5,   1, 1'b0, 8'h00,  2};
    vecs[1]  = '{1'b0, 1'b0, 4'h3, 8'h00,   1, 1'b0, 8'hA5,  2};
    vecs[2]  = '{1'b1, 1'b1, 4'hF, 8'hFF,   0, 1'b0, 8'h00,  1};
    vecs[3]  = '{1'b1, 1'b1, 4'h0, 8'h00,   0, 1'b0, 8'h00,  1};
    vecs[4]  = '{1'b0, 1'b0, 4'hF, 8'h00,   0, 1'b0, 8'hFF,  1};
    vecs[5]  = '{1'b0, 1'b0, 4'h0, 8'h00,   0, 1'b0, 8'h00,  1};
    vecs[6]  = '{1'b1, 1'b0, 4'h3, 8'h00,  14, 1'b0, 8'hA5, 15};
    vecs[7]  = '{1'b1, 1'b0, 4'hF, 8'h00,  15, 1'b1, 8'hA5, 15};
    vecs[8]  = '{1'b1, 1'b0, 4'hF, 8'h00, 255, 1'b1, 8'hA5, 15};
    vecs[9]  = '{1'b0, 1'b1, 4'h3, 8'h5A,  15, 1'b1, 8'h00, 15};
    vecs[10] = '{1'b0, 1'b0, 4'h3, 8'h00,   0, 1'b0, 8'hA5,  1};
    vecs[11] = '{1'b1, 1'b0, 4'hF, 8'h00,   3, 1'b0, 8'hFF,  4};

    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom);
      ram_mem[i] = v;
      mem_ref[i] = v;
    end
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_wr_rd = 1'b0; b_wr_rd = 1'b0;
    a_addr = 4'h0; b_addr = 4'h0; a_wdata = 8'h00; b_wdata = 8'h00;
    ram_ready = 1'b0; stray_ready = 1'b0; ready_delay = 0; vcnt = 0; hs_pend = 1'b0;
    busy = 1'b0; last_b = 1'b1; idle_from = 0; exp_ard = 8'h00; exp_brd = 8'h00;
    do_reset();

    // Vector table: single-requester transactions, boundaries and timeouts.
    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Stray ram_ready while idle or responding is ignored.
    stray_ready = 1'b1;
    repeat (4) step();
    run_vec(vecs[11], 12);
    stray_ready = 1'b0;

    // Command inputs changed during ISSUE must not reach the RAM port.
    ready_delay = 4;
    a_valid = 1'b1; a_wr_rd = 1'b0; a_addr = 4'h5; a_wdata = 8'h11;
    wait_grant("hold_grant");
    a_addr = 4'h9; a_wr_rd = 1'b1; a_wdata = 8'hEE;
    for (int k = 0; k < 30 && !ev_a; k++) begin
      if (ram_valid) begin
        chk("hold_addr", ram_addr, 4'h5);
        chk("hold_wr_rd", ram_wr_rd, 1'b0);
      end
      step();
    end
    if (!ev_a) note_fail("hold_done");
    drain();

    // Contention from reset: A first, then strict alternation, 3 cycles apart.
    do_reset();
    ready_delay = 0;
    a_valid = 1'b1; a_wr_rd = 1'b0; a_addr = 4'h1;
    b_valid = 1'b1; b_wr_rd = 1'b0; b_addr = 4'h2;
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      step();
      if (a_done || b_done) begin
        who[n] = b_done; tm[n] = cyc; n++;
      end
    end
    chk("cont_pulses", n, 4);
    for (int i = 0; i < n; i++) begin
      chk("cont_order", who[i], i % 2);
      if (i > 0) chk("cont_gap", tm[i] - tm[i-1], 3);
    end
    drain();

    // Reset during ISSUE of A's write: no done, command dropped, A wins next.
    ready_delay = 255;
    a_valid = 1'b1; a_wr_rd = 1'b1; a_addr = 4'h7; a_wdata = 8'h3C;
    wait_grant("midrst_grant");
    step(); step();
    a_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("midrst_valid", ram_valid, 0);
    chk("midrst_a_done", a_done, 0);
    rst = 1'b0;
    ready_delay = 0;
    a_valid = 1'b1; a_wr_rd = 1'b0; a_addr = 4'h7;
    b_valid = 1'b1; b_wr_rd = 1'b0; b_addr = 4'h2;
    for (int k = 0; k < 20 && !(ev_a || ev_b); k++) step();
    if (ev_a || ev_b) begin
      chk("postrst_first_a", a_done, 1);
      chk("postrst_first_b", b_done, 0);
    end else begin
      note_fail("postrst_wait");
    end
    drain();

    // Randomized traffic against the reference model.
    for (int k = 0; k < 1500; k++) begin
      step();
      rst = ($urandom_range(0, 399) == 0);
      stray_ready = 1'($urandom);
      if (!busy && $urandom_range(0, 1) == 0) ready_delay = pick_delay();
      if (ev_a) begin
        if ($urandom_range(0, 1) == 1) new_cmd(1'b0); else a_valid = 1'b0;
      end else if (!a_valid) begin
        if ($urandom_range(0, 2) == 0) new_cmd(1'b0);
      end else if (busy && !win_b && $urandom_range(0, 3) == 0) begin
        a_addr = 4'($urandom); a_wdata = 8'($urandom); a_wr_rd = 1'($urandom);
      end
      if (ev_b) begin
        if ($urandom_range(0, 1) == 1) new_cmd(1'b1); else b_valid = 1'b0;
      end else if (!b_valid) begin
        if ($urandom_range(0, 2) == 0) new_cmd(1'b1);
      end else if (busy && win_b && $urandom_range(0, 3) == 0) begin
        b_addr = 4'($urandom); b_wdata = 8'($urandom); b_wr_rd = 1'($urandom);
      end
    end
    rst = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter and sequencer for the 16 x 8 single-port RAM. It accepts read/write commands from requesters A and B, serialises them onto the RAM's single valid/ready command port, and returns read data and a one-cycle completion pulse to the winning requester. A cycle-count timeout recovers from a RAM that never asserts ready. It sits directly in front of Single_Port_RAM; nothing else drives the RAM.

## Interface
- ADDR_W, 4, RAM address width (16 words)
- DATA_W, 8, RAM data width
- TIMEOUT, 15, maximum cycles in ISSUE without ram_ready before abort (1..255)
- Clock is `clk` and reset is `rst`. There is one clock, and reset is synchronous and active-high.
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- a_valid / b_valid  in  1  request pending; held high with command stable until the matching done pulse
- a_wr_rd / b_wr_rd  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDR_W  target address
- a_wdata / b_wdata  in  DATA_W  write data
- a_done / b_done  out  1  one-cycle completion pulse
- a_err / b_err  out  1  valid with done; 1 = transaction timed out
- a_rdata / b_rdata  out  DATA_W  registered read data; updates only on a successful read
- ram_valid  out  1  command valid to RAM
- ram_wr_rd  out  1  command direction to RAM
- ram_addr  out  ADDR_W  address to RAM
- ram_wdata  out  DATA_W  write data to RAM
- ram_rdata  in  DATA_W  RAM read data; valid in the cycle ram_ready is high
- ram_ready  in  1  RAM completion; transaction ends on the edge where ram_valid && ram_ready

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any request is pending, latch the winner's command into the ram_* registers, set ram_valid=1, clear the timeout counter, and go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration: register last_grant resets to B.
  - If only one requester is pending, it wins.
  - If both are pending, the requester that is not last_grant wins.
  - last_grant updates when the grant is made.
- ISSUE: ram_* outputs stay constant.
  - ram_ready=1: ram_valid goes to 0. For a read, capture ram_rdata into the winner's rdata register. err=0. Go to RESP.
  - ram_ready=0 with counter == TIMEOUT-1: ram_valid goes to 0, err=1, rdata is unchanged. Go to RESP.
  - Otherwise increment the counter.
- RESP: assert the winner's done for exactly one cycle and drive its err. Go to IDLE. The loser's done and err stay 0.
- Requester rules:
  - A requester that still has valid high after its done is treated as a new request.
  - The new request is arbitrated normally in the next IDLE cycle.
- Writes never modify a_rdata or b_rdata.
- Reset values: state=IDLE, ram_valid=0, ram_wr_rd=0, ram_addr=0, ram_wdata=0, a/b_done=0, a/b_err=0, a/b_rdata=0, last_grant=B, counter=0.
- Reset mid-transaction: on the next edge ram_valid=0, no done pulse is issued, and the in-flight transaction is discarded.

## Timing
- A request sampled in IDLE at edge N gives ram_valid=1 after edge N.
- A ram_ready sampled at edge M gives done=1 and updated rdata after edge M, and IDLE after edge M+1.
- With a RAM that asserts ready in its first valid cycle, a transaction takes 3 cycles from grant to the next IDLE. Sustained throughput is 1 transaction per 3 cycles.
- Timeout: if ram_ready stays low, done/err assert after exactly TIMEOUT cycles of ram_valid=1.
- Simultaneous events:
  - A ram_ready arriving on the timeout cycle counts as success (err=0).
  - A ram_ready seen outside ISSUE is ignored.
- Requester command inputs are sampled only in IDLE. Changes while ISSUE or RESP is active have no effect.
- All outputs are registered, with no combinational paths from inputs to outputs.

## Test plan
- Single write, then single read:
  - Stimulus: A writes 8'hA5 to address 3 with ram_ready one cycle after ram_valid, then A reads address 3.
  - Required: a_done pulses twice, a_err=0, a_rdata=8'hA5, b_done never asserts.
- Contention:
  - Stimulus: a_valid and b_valid both high continuously, each with a read, just after reset.
  - Required: grants alternate A, B, A, B, and done pulses are 3 cycles apart.
- Timeout:
  - Stimulus: B issues a read, ram_ready is held 0, TIMEOUT=15.
  - Required: ram_valid is high for exactly 15 cycles, then b_done=1 with b_err=1 and b_rdata unchanged.
- Boundary address and data:
  - Stimulus: write 8'hFF to address 15 and 8'h00 to address 0, then read both back.
  - Required: read data matches, and ram_addr is 4'hF and then 4'h0 unwrapped.
- Reset mid-operation:
  - Stimulus: assert rst during ISSUE of A's write.
  - Required: ram_valid=0 after the next edge, no a_done pulse, all outputs at reset values. A request immediately after rst drops is granted to A first.
- Command stability:
  - Stimulus: change a_addr during ISSUE.
  - Required: ram_addr holds the originally latched value until ram_ready.
